// File: rtl/ysyx_24100005_data_sram.sv
// Word-organised data memory answering the LSU over a valid/ready request/response handshake.
// Latency: rsp_valid first rises LATENCY cycles after acceptance (plus lfsr[1:0] with random delay).
// Backpressure: one outstanding transaction; req_ready low outside IDLE; response held until rsp_ready.
//
// Ports: clk, rst (async, active high); request req_valid/req_ready/req_wen/req_addr/req_wdata/req_wmask;
//        response rsp_valid/rsp_ready/rsp_rdata/rsp_err.
// Optional macro YSYX_24100005_MEM_RAND_DELAY_EN adds a 0..3 cycle LFSR-driven extra delay per request.
module ysyx_24100005_data_sram #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [4:0] LAT5 = 5'(LATENCY);

    logic [1:0]            state;
    logic [4:0]            cnt;

    // Request fields captured at acceptance
    logic                  l_wen;
    logic                  l_inr;
    logic [DEPTH_LOG2-1:0] l_idx;
    logic [31:0]           l_wdata;
    logic [3:0]            l_wmask;

    logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

    logic [31:0]           off;
    logic                  in_range;
    logic                  accept;
    logic [4:0]            extra;
    logic [4:0]            total;
    logic                  commit;

    // Commit-side view: with a one-cycle total latency the commit happens on the
    // acceptance edge itself, so the live request fields must be used directly.
    logic                  c_wen;
    logic                  c_inr;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic [31:0]           c_wdata;
    logic [3:0]            c_wmask;

    // 32-bit wrap makes addresses below BASE huge, so one compare covers both ends.
    assign off      = req_addr - BASE;
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;

    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;

`ifdef YSYX_24100005_MEM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    assign total = LAT5 + extra;

    always_comb begin
        c_wen   = l_wen;
        c_inr   = l_inr;
        c_idx   = l_idx;
        c_wdata = l_wdata;
        c_wmask = l_wmask;
        if (state == S_IDLE) begin
            c_wen   = req_wen;
            c_inr   = in_range;
            c_idx   = off[DEPTH_LOG2+1:2];
            c_wdata = req_wdata;
            c_wmask = req_wmask;
        end
    end

    assign commit = ((state == S_IDLE) && accept && (total == 5'd1)) ||
                    ((state == S_WAIT) && (cnt == 5'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 5'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            l_wen     <= 1'b0;
            l_inr     <= 1'b0;
            l_idx     <= '0;
            l_wdata   <= 32'd0;
            l_wmask   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        l_wen   <= req_wen;
                        l_inr   <= in_range;
                        l_idx   <= off[DEPTH_LOG2+1:2];
                        l_wdata <= req_wdata;
                        l_wmask <= req_wmask;
                        if (total == 5'd1) begin
                            state <= S_RESP;
                        end else begin
                            cnt   <= total - 5'd2;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 5'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (commit) begin
                rsp_err   <= !c_inr;
                rsp_rdata <= (!c_wen && c_inr) ? mem[c_idx] : 32'd0;
            end
        end
    end

    // Array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && c_wen && c_inr) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wmask[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_data_sram.sv
module tb_ysyx_24100005_data_sram;

    localparam int          DL2   = 12;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 2;
    localparam int          WORDS = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    ysyx_24100005_data_sram #(.DEPTH_LOG2(DL2), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [0:WORDS-1];
    bit          pending = 0;
    longint      cyc = 0;
    longint      due = 0;
    bit          m_wen, m_was_pending, m_was_valid;
    logic [31:0] m_addr, m_wdata, m_rdata = 32'd0;
    logic [3:0]  m_wmask;
    bit          m_err = 0;

    function automatic bit addr_ok(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 0;
        end else begin
            m_was_pending = pending;
            m_was_valid   = pending && (cyc >= due);
            cyc++;
            if (m_was_valid && rsp_ready) begin
                pending = 0;
            end else if (!m_was_pending && req_valid) begin
                pending = 1;
                due     = cyc + LAT - 1;
                m_wen   = req_wen;
                m_addr  = req_addr;
                m_wdata = req_wdata;
                m_wmask = req_wmask;
            end
            if (pending && cyc == due) begin
                m_err   = !addr_ok(m_addr);
                m_rdata = 32'd0;
                if (addr_ok(m_addr)) begin
                    if (m_wen) begin
                        for (int i = 0; i < 4; i++)
                            if (m_wmask[i]) mm[addr_idx(m_addr)][8*i +: 8] = m_wdata[8*i +: 8];
                    end else begin
                        m_rdata = mm[addr_idx(m_addr)];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        ev = !rst && pending && (cyc >= due);
        chk("req_ready", {31'd0, req_ready}, {31'd0, !rst && !pending});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
        chk("rsp_rdata", rsp_rdata, ev ? m_rdata : 32'd0);
        chk("rsp_err",   {31'd0, rsp_err}, {31'd0, ev && m_err});
    end

    // ---------------- rsp_ready driver ----------------
    int rdy_mode = 0;   // 0 high, 1 low, 2 random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic issue(input bit wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = m;
        while (1) begin
            if (req_ready) begin
                @(posedge clk);
                break;
            end
            if (guard > 200) begin
                n_checks++; n_fail++;
                $display("FAIL issue_timeout: got no req_ready expected acceptance");
                break;
            end
            @(negedge clk);
            guard++;
        end
        #1;
        req_valid = 1'b0; req_wen = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wmask = 4'($urandom);
    endtask

    task automatic collect(output logic [31:0] rd, output logic err, output int lat);
        int n = 0;
        bit seen = 0;
        rd = 32'hx; err = 1'bx; lat = -1;
        while (1) begin
            @(negedge clk);
            n++;
            if (rsp_valid && !seen) begin seen = 1; lat = n; end
            if (rsp_valid && rsp_ready) begin
                rd = rsp_rdata; err = rsp_err;
                @(posedge clk);
                break;
            end
            if (n > 200) begin
                n_checks++; n_fail++;
                $display("FAIL collect_timeout: got no response expected handshake");
                break;
            end
        end
    endtask

    task automatic txn(input bit wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                       output logic [31:0] rd, output logic err, output int lat);
        issue(wen, a, wd, m);
        collect(rd, err, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd, v0, held, pre;
        logic        er;
        int          lat;

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // preload words 0..63
        for (int i = 0; i < 64; i++) txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rd, er, lat);

        // store then load
        txn(1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, rd, er, lat);
        chk("st_latency", 32'(lat), 32'd2);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", {31'd0, er}, 32'd0);
        txn(1'b0, 32'h8000_0013, 32'd0, 4'h0, rd, er, lat);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk("ld_latency", 32'(lat), 32'd2);

        // partial mask
        txn(1'b1, 32'h8000_0040, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h8000_0040, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1'b0, 32'h8000_0040, 32'd0, 4'h0, rd, er, lat);
        chk("partial_mask", rd, 32'h11BB33DD);

        // empty mask writes nothing
        txn(1'b1, 32'h8000_0040, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        txn(1'b0, 32'h8000_0040, 32'd0, 4'h0, rd, er, lat);
        chk("zero_mask", rd, 32'h11BB33DD);

        // out of range
        v0 = mm[0];
        txn(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, rd, er, lat);
        chk("oor_low_err", {31'd0, er}, 32'd1);
        chk("oor_low_rdata", rd, 32'd0);
        txn(1'b1, 32'h8000_4000, 32'h12345678, 4'hF, rd, er, lat);
        chk("oor_high_err", {31'd0, er}, 32'd1);
        txn(1'b0, BASE, 32'd0, 4'h0, rd, er, lat);
        chk("base_unchanged", rd, v0);
        txn(1'b0, 32'h8000_3FFC, 32'd0, 4'h0, rd, er, lat);
        chk("last_word_err", {31'd0, er}, 32'd0);

        // backpressure
        rdy_mode = 1;
        issue(1'b0, 32'h8000_0010, 32'd0, 4'h0);
        @(negedge clk); @(negedge clk);
        held = rsp_rdata;
        chk("bp_rdata", held, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata_held", rsp_rdata, 32'hDEADBEEF);
            chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        end
        rdy_mode = 0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);

        // reset mid-store (WAIT)
        pre = mm[8];
        issue(1'b1, 32'h8000_0020, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        txn(1'b0, 32'h8000_0020, 32'd0, 4'h0, rd, er, lat);
        chk("midrst_dropped", rd, pre);

        // reset while a response is held
        rdy_mode = 1;
        issue(1'b0, 32'h8000_0010, 32'd0, 4'h0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("resprst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("resprst_rdata", rsp_rdata, 32'd0);
        chk("resprst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        rdy_mode = 2;

        // randomized traffic, checked every cycle by the model compare
        for (int t = 0; t < 300; t++) begin
            int sel = $urandom_range(0, 9);
            logic [31:0] a;
            if (sel == 0)      a = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            else if (sel == 1) a = 32'h8000_4000 + 32'($urandom_range(0, 4095));
            else               a = BASE + 32'($urandom_range(0, 255));
            txn(1'($urandom), a, $urandom, 4'($urandom), rd, er, lat);
        end
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_data_sram.md
Name: ysyx_24100005_data_sram

Overview:
- Word-organised data memory that responds to the core's load/store requests.
- It is the responder end of the core's memory interface and replaces the DPI memory call with a timed valid/ready request/response protocol.
- Holds one outstanding transaction at a time, with a programmable access latency.
- Sits between the core's LSU and simulation memory; a later bus bridge will reuse the same handshake.

Parameters:
- DEPTH_LOG2, 12, log2 of word count (default 4096 words = 16 KiB).
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to first rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data, already lane-aligned.
- req_wmask  in  4  byte enables for a store; bit i enables byte lane i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  full load word (extraction and sign-extension are done by the core); 0 for stores and errors.
- rsp_err  out  1  address outside [BASE, BASE + 4*2^DEPTH_LOG2).

Behaviour:
- Reset (async, immediate):
  - State = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
  - req_ready = 0 while rst is high.
  - Memory array is not cleared.
  - A store accepted but not yet committed when reset asserts is dropped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid & req_ready are both high at a posedge.
  - On acceptance, latch wen, addr, wdata and wmask, and compute the range check.
  - If LATENCY == 1, go to RESP; otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; when the counter is 0, go to RESP at the next edge.
- Entry edge into RESP (commit):
  - Load, in range: rsp_rdata = mem[index] and rsp_err = 0.
  - Store, in range: byte lanes with wmask = 1 are written and the other lanes are unchanged. rsp_rdata = 0, rsp_err = 0. wmask = 4'b0000 writes nothing but still produces a response.
  - Out of range, load or store: no array access, rsp_rdata = 0, rsp_err = 1.
  - index = (addr - BASE) >> 2, taking the low DEPTH_LOG2 bits after the range check. Subtraction is 32-bit; an address below BASE wraps to a large value and fails the range check.
- RESP:
  - rsp_valid = 1 and req_ready = 0.
  - rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready at a posedge: go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Timing: if acceptance happens in cycle C, rsp_valid is first high in cycle C+LATENCY.
  - Back-to-back throughput is one transaction per LATENCY+1 cycles, assuming rsp_ready is tied high.
  - No new request is accepted in the same cycle as a response handshake.
- Read-after-write: a load accepted after a store's response handshake returns the stored data.
- Request inputs are ignored outside IDLE; the requester must hold them until acceptance.

Optional Feature:
- YSYX_24100005_MEM_RAND_DELAY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset, advances every cycle.
  - At acceptance, lfsr[1:0] (0..3) is added to the WAIT count, so response latency = LATENCY + lfsr[1:0].
  - Used to stress the core's stall logic.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

Test Plan:
- Reset then idle: rst = 1 at any time -> rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 immediately; after release req_ready = 1 within 1 cycle.
- Store then load, LATENCY = 2, rsp_ready = 1: store 0x8000_0010 data 0xDEADBEEF mask 4'hF -> rsp_valid 2 cycles after acceptance, rdata = 0, err = 0. Load 0x8000_0013 -> rdata = 0xDEADBEEF.
- Partial mask: word holds 0x11223344; store 0xAABBCCDD mask 4'b0101 -> subsequent load returns 0x11BB33DD.
- Out of range: load 0x7FFF_FFFC and store to 0x8000_4000 (DEPTH_LOG2 = 12) -> rsp_err = 1, rdata = 0. The word at BASE is unchanged after the store.
- Backpressure: load with rsp_ready = 0 for 5 cycles -> rsp_valid and rdata stay stable and req_ready stays 0. Raise rsp_ready -> IDLE next cycle.
- Reset mid-operation: assert rst in WAIT during a store to 0x8000_0020 -> outputs cleared at once. After reset, a load of 0x8000_0020 returns the pre-store value.
